hex_entry_ctrl: RTL and testbench
=================================

// Module: hex_entry_ctrl
// PURPOSE
//   Write-port sequencer for the 8-byte hex display register.
//   - Accepts hex digits (nibbles) and commands from the keyboard decode path.
//   - Packs each pair of digits into a byte, high nibble first.
//   - Issues one write per byte (wr_en/wr_addr/wr_data) at a cursor that advances 0..NUM_BYTES-1.
//   - Also sequences backspace and full-clear operations on the register.
// PARAMETERS
//   NUM_BYTES  8  number of byte slots in the target register (addresses 0..NUM_BYTES-1)
//   ADDR_W     4  width of wr_addr and cursor; must satisfy 2**ADDR_W >= NUM_BYTES
// PORTS
//   clock        in   1       system clock, rising edge
//   reset        in   1       asynchronous, active-low reset
//   digit_valid  in   1       digit strobe; accepted when digit_valid & ready
//   digit        in   4       hex digit value 0x0..0xF
//   bksp         in   1       backspace command strobe; accepted when bksp & ready
//   clear        in   1       clear-all command strobe; accepted when clear & ready
//   ready        out  1       controller can accept a digit or command this cycle
//   wr_en        out  1       one-cycle write strobe to the register
//   wr_addr      out  ADDR_W  byte slot being written
//   wr_data      out  8       byte being written
//   cursor       out  ADDR_W  next slot to be written
//   pending_hi   out  1       high nibble captured, low nibble awaited
//   full         out  1       all slots written (no-wrap build only; 0 otherwise)
// BEHAVIOUR
//   - Reset (async, active-low)
//     - State goes to S_HI.
//     - cursor=0, wr_en=0, wr_addr=0, wr_data=0x00, pending_hi=0, full=0, ready=0.
//     - ready rises on the first clock edge after reset deasserts.
//   - Reset mid-operation (including mid-CLEAR) aborts immediately. No further writes are issued.
//   - All outputs are registered.
//   - ready=1 only in S_HI/S_LO and only when not full.
//   - Inputs are ignored while ready=0 and are not queued.
//   - Same-cycle priority: clear > bksp > digit_valid. Only one of them is accepted per cycle.
//   - States:
//     - S_HI: no digit pending.
//       - digit accepted: hold it as the high nibble, pending_hi=1, go to S_LO.
//       - bksp accepted with cursor>0: cursor-=1, then write 0x00 at the new cursor via S_WR.
//       - bksp accepted with cursor==0: no-op.
//     - S_LO: high nibble held.
//       - digit accepted: go to S_WR with byte {hi,digit}.
//       - bksp accepted: discard the high nibble, pending_hi=0, go to S_HI. No write.
//     - S_WR: exactly one cycle.
//       - wr_en=1, wr_addr=cursor (post-decrement for bksp), wr_data=byte, ready=0.
//       - For digit writes, cursor advances on exit.
//       - Exit to S_HI with pending_hi=0.
//     - S_CLR: entered from S_HI or S_LO when clear is accepted; any held nibble is discarded.
//       - Issues NUM_BYTES consecutive writes of 0x00 to addresses 0..NUM_BYTES-1, one per cycle.
//       - ready=0 throughout.
//       - Then cursor=0, full=0, go to S_HI.
//   - Latency
//     - Low digit accepted at edge N: wr_en=1 in the cycle after edge N; ready returns after edge N+1.
//     - Clear accepted at edge N: writes occupy cycles N+1..N+NUM_BYTES; ready returns after edge N+NUM_BYTES.
//   - Cursor arithmetic is modulo NUM_BYTES (not modulo 2**ADDR_W).
//     - Wrap occurs from NUM_BYTES-1 to 0.
//   - wr_en is never asserted outside S_WR and S_CLR.
// CONFIGURATION
//   HEX_ENTRY_WRAP_EN defined:
//     - After a digit write at slot NUM_BYTES-1, cursor wraps to 0.
//     - Entry continues and overwrites the oldest bytes.
//     - full is tied to 0.
//   HEX_ENTRY_WRAP_EN undefined:
//     - After a digit write at slot NUM_BYTES-1, cursor stays at NUM_BYTES-1 and full=1.
//     - While full=1, ready=0 for digits; the next digit is not accepted.
//     - bksp and clear are still accepted while full (the ready=0 gating above applies to digits only).
//     - bksp while full clears slot NUM_BYTES-1 and leaves cursor=NUM_BYTES-1, full=0.
// TESTING
//   1 Release reset, enter digits 0xA then 0x5:
//     - One wr_en pulse with wr_addr=0, wr_data=0xA5.
//     - Then cursor=1, pending_hi=0.
//   2 Enter 0x1, then bksp:
//     - No write; pending_hi 1->0.
//     - Then enter 0x3, 0x4 -> write 0x34 at addr 1.
//   3 With cursor=2 and no digit pending, bksp:
//     - Single write 0x00 at addr 1; cursor=1.
//     - Repeat bksp twice -> write 0x00 at addr 0, then a no-op; cursor=0.
//   4 Assert clear and digit_valid in the same cycle:
//     - Clear wins: 8 consecutive writes of 0x00 at addr 0..7, ready=0 for 8 cycles.
//     - Afterwards cursor=0.
//   5 Enter 16 digits (bytes 0x00..0x77):
//     - WRAP_EN build: 17th/18th digits write at addr 0.
//     - No-wrap build: full=1, ready=0, 17th digit ignored.
//   6 Drop reset during S_CLR after 3 writes:
//     - wr_en=0 immediately; no further writes.
//     - cursor=0; ready=1 one cycle after reset release.

Source files
------------

// File: rtl/hex_entry_ctrl.sv
// hex_entry_ctrl
//   Write-port sequencer for an 8-byte hex display register. It takes
//   keyboard hex digits and packs each pair into one byte, high nibble
//   first. It writes each byte at a cursor that moves up through
//   0..NUM_BYTES-1. It also handles backspace and a full clear of the
//   register.
//
//   Build option: define HEX_ENTRY_WRAP_EN to let the cursor wrap from the
//   last slot back to 0. Entry then overwrites the oldest bytes and o_full
//   stays 0. With the macro undefined, the cursor stops at the last slot and
//   o_full is raised.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_digit_valid  digit strobe, taken when o_ready=1
//   i_digit        hex digit 0x0..0xF
//   i_bksp         backspace strobe
//   i_clear        clear-all strobe (highest priority)
//   o_ready        a digit can be taken this cycle
//   o_wr_en        one-cycle write strobe to the register
//   o_wr_addr      slot being written
//   o_wr_data      byte being written
//   o_cursor       next slot to be written
//   o_pending_hi   high nibble held, low nibble awaited
//   o_full         all slots written (no-wrap build only)
//
// state | meaning
// ------+-------------------------------------------------------------
// S_HI  | idle, no nibble held
// S_LO  | high nibble held, waiting for the low nibble
// S_WR  | single write cycle (digit byte or backspace 0x00)
// S_CLR | writing 0x00 to every slot, one slot per cycle
module hex_entry_ctrl #(
  parameter int NUM_BYTES = 8,
  parameter int ADDR_W    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_digit_valid,
  input  logic [3:0]        i_digit,
  input  logic              i_bksp,
  input  logic              i_clear,
  output logic              o_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic [ADDR_W-1:0] o_cursor,
  output logic              o_pending_hi,
  output logic              o_full
);

  typedef enum logic [1:0] {
    S_HI  = 2'd0,
    S_LO  = 2'd1,
    S_WR  = 2'd2,
    S_CLR = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(NUM_BYTES - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cursor;
  logic [3:0]        r_hi;
  logic              r_pending_hi;
  logic              r_full;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_wr_digit;
  logic              r_idle;
  logic              r_ready;

  state_t            w_state_nx;
  logic [ADDR_W-1:0] w_cursor_nx;
  logic [3:0]        w_hi_nx;
  logic              w_pending_nx;
  logic              w_full_nx;
  logic              w_wr_en_nx;
  logic [ADDR_W-1:0] w_wr_addr_nx;
  logic [7:0]        w_wr_data_nx;
  logic              w_wr_digit_nx;
  logic              w_idle_nx;
  logic              w_ready_nx;
  logic              w_take_clr;
  logic              w_take_bksp;
  logic              w_take_dig;

  // r_idle: commands may be taken (S_HI/S_LO, after the first edge out of
  // reset). Digits also need !full, and that is what o_ready shows.
  assign w_take_clr  = r_idle & i_clear;
  assign w_take_bksp = r_idle & i_bksp & ~i_clear;
  assign w_take_dig  = r_ready & i_digit_valid & ~i_clear & ~i_bksp;

  always_comb begin
    w_state_nx    = r_state;
    w_cursor_nx   = r_cursor;
    w_hi_nx       = r_hi;
    w_pending_nx  = r_pending_hi;
    w_full_nx     = r_full;
    w_wr_en_nx    = 1'b0;
    w_wr_addr_nx  = r_wr_addr;
    w_wr_data_nx  = r_wr_data;
    w_wr_digit_nx = r_wr_digit;

    case (r_state)
      S_HI, S_LO: begin
        if (w_take_clr) begin
          w_state_nx   = S_CLR;
          w_pending_nx = 1'b0;
          w_wr_en_nx   = 1'b1;
          w_wr_addr_nx = '0;
          w_wr_data_nx = 8'h00;
        end else if (w_take_bksp) begin
          if (r_state == S_LO) begin
            w_state_nx   = S_HI;
            w_pending_nx = 1'b0;
          end else if (r_full) begin
            // The last slot is filled and the cursor is still on it, so
            // clear that slot in place.
            w_state_nx    = S_WR;
            w_full_nx     = 1'b0;
            w_wr_en_nx    = 1'b1;
            w_wr_addr_nx  = r_cursor;
            w_wr_data_nx  = 8'h00;
            w_wr_digit_nx = 1'b0;
          end else if (r_cursor != '0) begin
            w_state_nx    = S_WR;
            w_cursor_nx   = r_cursor - ONE;
            w_wr_en_nx    = 1'b1;
            w_wr_addr_nx  = r_cursor - ONE;
            w_wr_data_nx  = 8'h00;
            w_wr_digit_nx = 1'b0;
          end
        end else if (w_take_dig) begin
          if (r_state == S_HI) begin
            w_state_nx   = S_LO;
            w_hi_nx      = i_digit;
            w_pending_nx = 1'b1;
          end else begin
            w_state_nx    = S_WR;
            w_pending_nx  = 1'b0;
            w_wr_en_nx    = 1'b1;
            w_wr_addr_nx  = r_cursor;
            w_wr_data_nx  = {r_hi, i_digit};
            w_wr_digit_nx = 1'b1;
          end
        end
      end

      S_WR: begin
        w_state_nx   = S_HI;
        w_pending_nx = 1'b0;
        if (r_wr_digit) begin
          if (r_cursor == LAST_SLOT) begin
`ifdef HEX_ENTRY_WRAP_EN
            w_cursor_nx = '0;
`else
            w_full_nx   = 1'b1;
`endif
          end else begin
            w_cursor_nx = r_cursor + ONE;
          end
        end
      end

      S_CLR: begin
        // r_wr_addr is the clear sweep counter.
        if (r_wr_addr == LAST_SLOT) begin
          w_state_nx  = S_HI;
          w_cursor_nx = '0;
          w_full_nx   = 1'b0;
        end else begin
          w_wr_en_nx   = 1'b1;
          w_wr_addr_nx = r_wr_addr + ONE;
          w_wr_data_nx = 8'h00;
        end
      end

      default: w_state_nx = S_HI;
    endcase

    w_idle_nx  = (w_state_nx == S_HI) || (w_state_nx == S_LO);
    w_ready_nx = w_idle_nx & ~w_full_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_HI;
      r_cursor     <= '0;
      r_hi         <= 4'h0;
      r_pending_hi <= 1'b0;
      r_full       <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 8'h00;
      r_wr_digit   <= 1'b0;
      r_idle       <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cursor     <= w_cursor_nx;
      r_hi         <= w_hi_nx;
      r_pending_hi <= w_pending_nx;
      r_full       <= w_full_nx;
      r_wr_en      <= w_wr_en_nx;
      r_wr_addr    <= w_wr_addr_nx;
      r_wr_data    <= w_wr_data_nx;
      r_wr_digit   <= w_wr_digit_nx;
      r_idle       <= w_idle_nx;
      r_ready      <= w_ready_nx;
    end
  end

  assign o_ready      = r_ready;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_cursor     = r_cursor;
  assign o_pending_hi = r_pending_hi;
  assign o_full       = r_full;

endmodule

// File: tb/tb_hex_entry_ctrl.sv
module tb_hex_entry_ctrl;

  logic       clk;
  logic       rst_n;
  logic       digit_valid;
  logic [3:0] digit;
  logic       bksp;
  logic       clear;
  logic       ready;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] cursor;
  logic       pending_hi;
  logic       full;

  int n_tests = 0;
  int n_fail  = 0;

  hex_entry_ctrl #(.NUM_BYTES(8), .ADDR_W(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_digit_valid (digit_valid),
    .i_digit       (digit),
    .i_bksp        (bksp),
    .i_clear       (clear),
    .o_ready       (ready),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_cursor      (cursor),
    .o_pending_hi  (pending_hi),
    .o_full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       bk;
    logic       dv;
    logic [3:0] dg;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] cur;
    logic       pend;
    logic       rdy;
    logic       fl;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic b, input logic v, input logic [3:0] d);
    clear = c; bksp = b; digit_valid = v; digit = d;
    tick();
    clear = 1'b0; bksp = 1'b0; digit_valid = 1'b0; digit = 4'h0;
  endtask

  // status word: {wr_en, wr_addr, wr_data, cursor, pending_hi, ready, full}
  function automatic logic [31:0] pack(input logic w, input logic [3:0] a, input logic [7:0] d,
                                       input logic [3:0] c, input logic p, input logic r,
                                       input logic f);
    return {11'd0, w, a, d, c, p, r, f};
  endfunction

  function automatic logic [31:0] actual(input logic mask_wr);
    if (mask_wr) return pack(wr_en, 4'h0, 8'h00, cursor, pending_hi, ready, full);
    return pack(wr_en, wr_addr, wr_data, cursor, pending_hi, ready, full);
  endfunction

  initial begin
    //         clr bk dv dg     wr addr  data   cur  pend rdy full
    vecs[0]  = '{0, 0, 1, 4'hA, 0, 4'd0, 8'h00, 4'd0, 1, 1, 0};
    vecs[1]  = '{0, 0, 1, 4'h5, 1, 4'd0, 8'hA5, 4'd0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 4'h0, 0, 4'd0, 8'h00, 4'd1, 0, 1, 0};
    vecs[3]  = '{0, 0, 1, 4'h1, 0, 4'd0, 8'h00, 4'd1, 1, 1, 0};
    vecs[4]  = '{0, 1, 0, 4'h0, 0, 4'd0, 8'h00, 4'd1, 0, 1, 0};
    vecs[5]  = '{0, 0, 1, 4'h3, 0, 4'd0, 8'h00, 4'd1, 1, 1, 0};
    vecs[6]  = '{0, 0, 1, 4'h4, 1, 4'd1, 8'h34, 4'd1, 0, 0, 0};
    vecs[7]  = '{0, 0, 0, 4'h0, 0, 4'd0, 8'h00, 4'd2, 0, 1, 0};
    vecs[8]  = '{0, 1, 0, 4'h0, 1, 4'd1, 8'h00, 4'd1, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 4'h0, 0, 4'd0, 8'h00, 4'd1, 0, 1, 0};
    vecs[10] = '{0, 1, 0, 4'h0, 1, 4'd0, 8'h00, 4'd0, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 4'h0, 0, 4'd0, 8'h00, 4'd0, 0, 1, 0};
    vecs[12] = '{0, 1, 0, 4'h0, 0, 4'd0, 8'h00, 4'd0, 0, 1, 0};
    vecs[13] = '{0, 0, 1, 4'h7, 0, 4'd0, 8'h00, 4'd0, 1, 1, 0};
    vecs[14] = '{0, 0, 1, 4'h8, 1, 4'd0, 8'h78, 4'd0, 0, 0, 0};
    // digit offered during the write cycle (ready=0) must be dropped
    vecs[15] = '{0, 0, 1, 4'h9, 0, 4'd0, 8'h00, 4'd1, 0, 1, 0};
    vecs[16] = '{0, 1, 0, 4'h0, 1, 4'd0, 8'h00, 4'd0, 0, 0, 0};
    vecs[17] = '{0, 0, 0, 4'h0, 0, 4'd0, 8'h00, 4'd0, 0, 1, 0};

    rst_n = 1'b1; clear = 1'b0; bksp = 1'b0; digit_valid = 1'b0; digit = 4'h0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", actual(1'b0), pack(0, 4'd0, 8'h00, 4'd0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", {31'd0, ready}, 32'd0);
    tick();
    check("ready_after_release", actual(1'b0), pack(0, 4'd0, 8'h00, 4'd0, 0, 1, 0));

    // table: digit packing, nibble backspace, byte backspace, dropped input
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].clr, vecs[i].bk, vecs[i].dv, vecs[i].dg);
      check($sformatf("vec%0d", i), actual(!vecs[i].wr),
            pack(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].cur,
                 vecs[i].pend, vecs[i].rdy, vecs[i].fl));
    end

    // clear beats a same-cycle digit and discards a held nibble
    drive(0, 0, 1, 4'h1);
    drive(0, 0, 1, 4'h2);
    check("pre_clr_write", actual(1'b0), pack(1, 4'd0, 8'h12, 4'd0, 0, 0, 0));
    tick();
    drive(0, 0, 1, 4'h3);
    check("pre_clr_pending", actual(1'b1), pack(0, 4'd0, 8'h00, 4'd1, 1, 1, 0));
    drive(1, 0, 1, 4'h5);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("clr_wr%0d", i), actual(1'b0),
            pack(1, 4'(i), 8'h00, 4'd1, 0, 0, 0));
      tick();
    end
    check("clr_done", actual(1'b1), pack(0, 4'd0, 8'h00, 4'd0, 0, 1, 0));

    // sixteen digits fill all eight slots
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 1, 4'(k));
      drive(0, 0, 1, 4'(k));
      check($sformatf("fill_wr%0d", k), actual(1'b0),
            pack(1, 4'(k), {4'(k), 4'(k)}, 4'(k), 0, 0, 0));
      tick();
    end
`ifdef HEX_ENTRY_WRAP_EN
    check("wrap_cursor", actual(1'b1), pack(0, 4'd0, 8'h00, 4'd0, 0, 1, 0));
    drive(0, 0, 1, 4'hF);
    drive(0, 0, 1, 4'hE);
    check("wrap_write", actual(1'b0), pack(1, 4'd0, 8'hFE, 4'd0, 0, 0, 0));
    tick();
    check("wrap_after", actual(1'b1), pack(0, 4'd0, 8'h00, 4'd1, 0, 1, 0));
`else
    check("full_set", actual(1'b1), pack(0, 4'd0, 8'h00, 4'd7, 0, 0, 1));
    drive(0, 0, 1, 4'hF);
    check("full_dig_ignored", actual(1'b1), pack(0, 4'd0, 8'h00, 4'd7, 0, 0, 1));
    drive(0, 1, 0, 4'h0);
    check("full_bksp_wr", actual(1'b0), pack(1, 4'd7, 8'h00, 4'd7, 0, 0, 0));
    tick();
    check("full_bksp_after", actual(1'b1), pack(0, 4'd0, 8'h00, 4'd7, 0, 1, 0));
`endif

    // reset in the middle of a clear sweep
    drive(1, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort_wr%0d", i), {28'd0, wr_en, wr_addr[2:0]}, {28'd0, 1'b1, 3'(i)});
      if (i < 2) tick();
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_immediate", actual(1'b1), pack(0, 4'd0, 8'h00, 4'd0, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("abort_hold%0d", i), {31'd0, wr_en}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort_release", actual(1'b1), pack(0, 4'd0, 8'h00, 4'd0, 0, 1, 0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_quiet%0d", i), {31'd0, wr_en}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
